// File: rtl/symbol_bit_framer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | symbol_bit_framer_if : valid/ready word handshake into symbol_bit_framer  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface symbol_bit_framer_if #(
  parameter int W = 8
);
  logic [W-1:0] Data;
  logic         Valid;
  logic         Ready;

  modport master (output Data, output Valid, input Ready);
  modport slave  (input Data, input Valid, output Ready);
endinterface
`default_nettype wire

// File: rtl/symbol_bit_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | symbol_bit_framer : preamble + word serialiser, one bit per SYM_LEN clks  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module symbol_bit_framer #(
  parameter int                 SYM_LEN  = 13,
  parameter int                 W        = 8,
  parameter int                 PRE_LEN  = 4,
  parameter logic [PRE_LEN-1:0] PRE_PAT  = 4'b0101,
  parameter logic               IDLE_BIT = 1'b0
) (
  input  wire logic          C,
  input  wire logic          Reset,
  symbol_bit_framer_if.slave in_if,
  output logic               Bit,
  output logic               Sym_start,
  output logic               Busy
);

  localparam int M       = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int IDX_MAX = (W > PRE_LEN) ? W : PRE_LEN;
  localparam int IW      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  localparam logic [M-1:0]  LAST_PHASE = M'(SYM_LEN - 1);
  localparam logic [IW-1:0] PRE_LAST   = IW'(PRE_LEN - 1);
  localparam logic [IW-1:0] DATA_LAST  = IW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [M-1:0]       phase_q, phase_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               bit_q, bit_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [PRE_LEN-1:0] pre_q, pre_d;
  logic [W-1:0]       buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               ready_q;
  logic               boundary;
  logic               load;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pre_d      = pre_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load       = 1'b0;
    boundary   = (phase_q == LAST_PHASE);
    phase_d    = boundary ? '0 : phase_q + M'(1);

    // Ready mirrors an empty buffer, so accept and load never coincide.
    if (in_if.Valid && ready_q) begin
      buf_d      = in_if.Data;
      buf_full_d = 1'b1;
    end

    if (boundary) begin
      unique case (state_q)
        S_IDLE: begin
          if (buf_full_q) load = 1'b1;
          else            bit_d = IDLE_BIT;
        end
        S_PRE: begin
          if (idx_q != PRE_LAST) begin
            idx_d = idx_q + IW'(1);
            bit_d = pre_q[0];
            pre_d = pre_q >> 1;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            bit_d   = shreg_q[W-1];
            shreg_d = shreg_q << 1;
          end
        end
        S_DATA: begin
          if (idx_q != DATA_LAST) begin
            idx_d   = idx_q + IW'(1);
            bit_d   = shreg_q[W-1];
            shreg_d = shreg_q << 1;
          end else if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            bit_d   = IDLE_BIT;
          end
        end
        default: begin
          state_d = S_IDLE;
          bit_d   = IDLE_BIT;
        end
      endcase
    end

    if (load) begin
      state_d    = S_PRE;
      idx_d      = '0;
      bit_d      = PRE_PAT[0];
      pre_d      = PRE_PAT >> 1;
      shreg_d    = buf_q;
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge C) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      idx_q      <= '0;
      bit_q      <= IDLE_BIT;
      shreg_q    <= '0;
      pre_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      pre_q      <= pre_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ready_q    <= !buf_full_d;
    end
  end

  assign in_if.Ready = ready_q;
  assign Bit         = bit_q;
  assign Sym_start   = (phase_q == '0);
  assign Busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/symbol_bit_framer.md
Name: symbol_bit_framer

Overview:
- Upstream stage of the ROM pulse-shaping signal generator. Accepts parallel data words over a valid/ready handshake.
- Prepends a fixed preamble to each word, then emits the frame one bit per symbol period on Bit. Bit drives the generator's In input.
- Bit changes only on symbol boundaries. Each bit is held for exactly SYM_LEN clocks, so each ROM waveform pass plays one bit when both blocks share C and Reset.

Parameters:
- SYM_LEN, 13: clocks per symbol; equals the generator's SIZE.
- W, 8: data word width.
- PRE_LEN, 4: preamble length in bits (>=1).
- PRE_PAT, 4'b0101: preamble pattern, sent LSB first.
- IDLE_BIT, 0: Bit level while no frame is active.
- m, $clog2(SYM_LEN): phase counter width.

Ports:
- C, input, 1: clock; all logic on posedge C.
- Reset, input, 1: synchronous, active-high reset.
- Data, input, W: word to transmit.
- Valid, input, 1: Data is valid.
- Ready, output, 1: holding buffer empty; a word is accepted on a posedge where Valid && Ready.
- Bit, output, 1: serial symbol bit to the generator's In.
- Sym_start, output, 1: high during the first clock of every symbol (phase == 0).
- Busy, output, 1: a frame is in progress (state != IDLE).

Behaviour:
- Reset (synchronous, Reset==1 at posedge):
  - phase=0, state=IDLE, buffer empty.
  - Bit=IDLE_BIT, Ready=1, Busy=0, Sym_start=1 (phase==0).
  - Reset overrides everything, including mid-frame; any partial frame and buffered word are discarded.
- Phase counter:
  - Free-runs 0..SYM_LEN-1 and wraps to 0.
  - "Boundary edge" = the posedge where phase==SYM_LEN-1.
  - Bit, state and bit index update only on boundary edges, so each new Bit value is first visible in the phase==0 cycle.
- Holding buffer (1 deep):
  - Written on Valid && Ready.
  - Ready = !buf_full, registered.
  - The buffer is freed on the boundary edge that loads it into the shift register. Ready rises in the following cycle.
- FSM transitions, evaluated on boundary edges only:
  - IDLE, buffer full: load shift register, clear buffer, idx=0, Bit=PRE_PAT[0], go to PRE.
  - IDLE, buffer empty: Bit=IDLE_BIT.
  - PRE: if idx<PRE_LEN-1, idx++ and Bit=PRE_PAT[idx+1]. Otherwise go to DATA, idx=0, Bit=shreg[W-1] (MSB first).
  - DATA: if idx<W-1, idx++ and Bit=shreg[W-2-idx] (shift left). Otherwise the frame is done:
    - buffer full: reload, Bit=PRE_PAT[0], go to PRE. Frames are back-to-back with no idle symbol.
    - buffer empty: Bit=IDLE_BIT, go to IDLE.
- Frame timing:
  - Frame length = (PRE_LEN+W)*SYM_LEN clocks; 156 symbols-clocks for defaults (12 symbols × 13).
- Simultaneous events:
  - Word accepted on the same boundary edge where IDLE samples an empty buffer: the frame starts on the next boundary edge, not this one.
  - Valid held while Ready=0: no accept, Data ignored; the upstream source must hold Data.
  - Valid deasserted with Ready=1: nothing accepted.
- Latency: from acceptance to the first preamble bit is between 1 and SYM_LEN clocks plus one symbol (next boundary not coinciding with the accept edge).

Test Plan:
- Reset values: hold Reset 3 cycles, release -> Bit=0, Ready=1, Busy=0. Sym_start is high in cycles 0, 13, 26 after release. Bit stays 0 indefinitely with no Valid.
- Single word: Valid=1, Data=8'hA5 in cycle 0 after reset -> accepted at edge 0, Ready=0 in cycle 1. The frame starts at the edge ending cycle 12.
  - Bit over 12 symbols (cycles 13..168) = 1,0,1,0, then 1,0,1,0,0,1,0,1.
  - Bit returns to 0 from cycle 169; Busy=0 from cycle 169.
- Back-to-back: 8'hFF then 8'h00, second offered as soon as Ready rises -> 24 consecutive symbols: 1010 11111111 1010 00000000. No IDLE symbol between frames; Busy stays 1 throughout.
- Backpressure: hold Valid=1 with changing Data while Ready=0 -> no extra word is transmitted. The word present when Ready returns to 1 is the one accepted.
- Reset mid-frame: assert Reset during the 3rd data bit -> next cycle Bit=0, Busy=0, Ready=1, phase=0. A new word 8'h3C afterwards transmits correctly with the preamble.
- Boundary accept: offer a word exactly on a boundary edge while IDLE -> Bit stays IDLE_BIT for one more symbol, then the preamble starts on the next boundary.
